// File: rtl/uart_tx_sched.sv
// uart_tx_sched: frame scheduler for the UART transmit path.
// It accepts one word on each valid/ready handshake and sends it on the
// serial line as: a start bit, the data bits LSB first, an optional parity
// bit, then one or two stop bits. Every bit lasts baud_div clock cycles.
// The divisor and the frame options are latched at accept, so changes
// made mid-frame only take effect on the next frame.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   baud_div     clock cycles per bit (0 is treated as 1)
//   parity_en    add a parity bit; parity_odd selects odd (1) or even (0)
//   stop2        two stop bits instead of one
//   tx_data      word to send; tx_valid / tx_ready form the handshake
//   tx           serial output (registered, idles high)
//   busy         a frame is in progress (registered)
module uart_tx_sched #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [IDX_W-1:0]    r_bit_idx, w_bit_idx_nxt;
  logic                r_stop_idx, w_stop_idx_nxt;
  logic                r_par, r_par_en, r_stop2;
  logic                r_tx, r_ready, r_busy;
  logic                w_tx_nxt, w_ready_nxt, w_busy_nxt;
  logic                w_accept, w_bit_end, w_last_stop, w_data_end;
  logic [DIV_W-1:0]    w_div_eff;

  assign w_accept    = tx_valid && r_ready;
  assign w_bit_end   = (r_state != S_IDLE) && (r_cnt == r_div - 1'b1);
  assign w_data_end  = w_bit_end && (r_state == S_DATA) &&
                       (r_bit_idx == IDX_W'(DATA_W - 1));
  // r_stop_idx counts stop bits already sent; the last one has index stop2.
  assign w_last_stop = w_bit_end && (r_state == S_STOP) && (r_stop_idx == r_stop2);
  assign w_div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;

  // State register plus frame datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= DIV_W'(1);
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      if (w_accept) begin
        r_par    <= (^tx_data) ^ parity_odd;
        r_par_en <= parity_en;
        r_stop2  <= stop2;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_START;
      S_START:  if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:   if (w_data_end) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_last_stop) w_state_nxt = w_accept ? S_START : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Counter, shift register and bit indices for the next cycle
  always_comb begin
    w_cnt_nxt      = r_cnt + 1'b1;
    w_div_nxt      = r_div;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    if (w_accept || w_bit_end || r_state == S_IDLE) w_cnt_nxt = '0;
    if (w_accept) begin
      w_div_nxt      = w_div_eff;
      w_shift_nxt    = tx_data;
      w_bit_idx_nxt  = '0;
      w_stop_idx_nxt = 1'b0;
    end else if (w_bit_end && r_state == S_DATA) begin
      w_shift_nxt   = r_shift >> 1;
      w_bit_idx_nxt = w_data_end ? '0 : r_bit_idx + 1'b1;
    end else if (w_bit_end && r_state == S_STOP) begin
      w_stop_idx_nxt = !w_last_stop;
    end
  end

  // Registered outputs are computed from the next state so that tx falls
  // on the accept edge and tx_ready rises on the edge that opens the last
  // cycle of the final stop bit.
  always_comb begin
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_ready_nxt = 1'b0;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
    if (w_state_nxt == S_IDLE)
      w_ready_nxt = 1'b1;
    else if (w_state_nxt == S_STOP && w_stop_idx_nxt == r_stop2 &&
             w_cnt_nxt == r_div - 1'b1)
      w_ready_nxt = 1'b1;
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx, busy;

  uart_tx_sched #(.DIV_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         pen;
    bit         par;
    bit         s2;
    bit         b2b;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   frames_done = 0, frames_aborted = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line level for bit b of a frame: start, 8 data bits, parity, stops.
  function automatic logic ebit(input exp_t e, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return e.d[b-1];
    if (e.pen && b == 9) return e.par;
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  exp_t       cur;
  bit         in_frame = 0, just_ended = 0;
  int         k, tot, m_tx, m_rdy, m_bsy;
  logic [7:0] obs_d;
  longint     cyc = 0, prev_start = 0, prev_len = 0;

  task automatic mon_cycle();
    int b;
    b = k / cur.div;
    if (tx !== ebit(cur, b)) m_tx++;
    if (tx_ready !== (k == tot - 1)) m_rdy++;
    if (busy !== 1'b1) m_bsy++;
    if (k % cur.div == 0 && b >= 1 && b <= 8) obs_d[b-1] = tx;
    k++;
    if (k == tot) begin
      chk("frame_tx_cycles", m_tx, 0);
      chk("frame_ready_cycles", m_rdy, 0);
      chk("frame_busy_cycles", m_bsy, 0);
      chk("frame_data", obs_d, cur.d);
      in_frame    = 0;
      just_ended  = 1;
      frames_done++;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      if (in_frame) frames_aborted++;
      in_frame   = 0;
      just_ended = 0;
    end else if (in_frame) begin
      mon_cycle();
    end else if (tx === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_start", 1, 0);
        cur = '{d: 8'h00, div: 1, pen: 1'b0, par: 1'b0, s2: 1'b0, b2b: 1'b0};
      end else begin
        cur = q.pop_front();
      end
      if (cur.b2b) chk("b2b_start_gap", cyc - prev_start, prev_len);
      tot        = (10 + int'(cur.pen) + int'(cur.s2)) * cur.div;
      prev_start = cyc;
      prev_len   = tot;
      k = 0; m_tx = 0; m_rdy = 0; m_bsy = 0; obs_d = '0;
      in_frame   = 1;
      just_ended = 0;
      mon_cycle();
    end else if (just_ended) begin
      chk("idle_after_frame", {tx_ready, busy}, 2'b10);
      just_ended = 0;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [7:0] d, input logic [15:0] dv,
                      input bit pen, input bit podd, input bit s2, input bit b2b);
    exp_t e;
    int   n;
    n = 0;
    tx_data = d; baud_div = dv; parity_en = pen; parity_odd = podd;
    stop2 = s2; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      chk("accept_timeout", tx_ready, 1);
    end else begin
      e.d   = d;
      e.div = (dv == 16'd0) ? 1 : int'(dv);
      e.pen = pen;
      e.par = (^d) ^ podd;
      e.s2  = s2;
      e.b2b = b2b;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("frames_done", frames_done, target);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; baud_div = 16'd4; parity_en = 0; parity_odd = 0; stop2 = 0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x55, div 4, 8N1: 40-cycle frame
    send(8'h55, 16'd4, 0, 0, 0, 0); tx_valid = 0; wait_frames(1);
    // even then odd parity on 0x07, div 3
    send(8'h07, 16'd3, 1, 0, 0, 0); tx_valid = 0; wait_frames(2);
    send(8'h07, 16'd3, 1, 1, 0, 0); tx_valid = 0; wait_frames(3);
    // back-to-back, valid held high: second start 24 cycles after first
    send(8'hA5, 16'd2, 1, 0, 1, 0);
    send(8'h3C, 16'd2, 1, 0, 1, 1); tx_valid = 0; wait_frames(5);
    // divisor 0 behaves as 1
    send(8'h96, 16'd0, 0, 0, 0, 0); tx_valid = 0; wait_frames(6);
    // config change mid-frame must not disturb the current frame
    send(8'hC3, 16'd4, 0, 0, 0, 0); tx_valid = 0;
    repeat (6) @(negedge clk);
    baud_div = 16'd9; parity_en = 1; stop2 = 1;
    wait_frames(7);
    send(8'h3A, 16'd9, 0, 0, 0, 0); tx_valid = 0; wait_frames(8);

    // reset during data bit 3 of 0x00
    send(8'h00, 16'd4, 0, 0, 0, 0); tx_valid = 0;
    repeat (17) @(negedge clk);
    #2;
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("frames_aborted", frames_aborted, 1);
    send(8'h5A, 16'd4, 0, 0, 0, 0); tx_valid = 0; wait_frames(9);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
